// File: rtl/univ_shift_reg_n.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_n
//
// Parametrised universal shift register with an autonomous burst engine.
// One step can hold, shift (logical left/right, arithmetic right), rotate or
// parallel-load the register. A burst runs a latched shift/rotate mode for a
// programmed number of steps. The en input can stall a burst.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (wins over everything)
//   en         step enable: single step when idle, run/stall when busy
//   mode       operation select (HOLD/SHR/SHL/LOAD/ROTR/ROTL/ASHR/rsvd)
//   msb_in     serial input shifted in at the top on SHR steps
//   lsb_in     serial input shifted in at the bottom on SHL steps
//   load_data  parallel load value
//   start      burst request, sampled only while idle
//   count      burst step count, sampled with start
//   q          register contents
//   sout_r     q[0]
//   sout_l     q[WIDTH-1]
//   busy       burst in progress
//   done       one-cycle burst-complete pulse
//
// Burst handshake: a request is start=1 together with a shift/rotate mode,
// sampled at an edge while busy=0. A request with count>0 is accepted at
// that edge and raises busy from the next cycle. No step happens on the
// accepting edge. Each later edge with en=1 performs one step. The edge that
// performs the last step drops busy and raises done for exactly one cycle.
// A request with count=0 raises done for one cycle and never raises busy.
// Requests are ignored while busy=1. They are accepted again in the done
// cycle.
// -----------------------------------------------------------------------------
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROTR = 3'b100;
    localparam logic [2:0] M_ROTL = 3'b101;
    localparam logic [2:0] M_ASHR = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] remaining, remaining_next;
    logic [2:0]       run_mode, run_mode_next;
    logic [WIDTH-1:0] q_next;
    logic             done_next;

    // Result of one step of mode m applied to v. Reserved mode 111 holds.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             mi,
        input logic             li,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            M_HOLD: r = v;
            M_SHR:  r = {mi, v[WIDTH-1:1]};
            M_SHL:  r = {v[WIDTH-2:0], li};
            M_LOAD: r = ld;
            M_ROTR: r = {v[0], v[WIDTH-1:1]};
            M_ROTL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ASHR: r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Only shift/rotate modes can start a burst. HOLD, LOAD and rsvd fall
    // back to ordinary idle single-step behaviour even with start high.
    function automatic logic is_shift(input logic [2:0] m);
        return (m == M_SHR) || (m == M_SHL) || (m == M_ROTR) ||
               (m == M_ROTL) || (m == M_ASHR);
    endfunction

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        run_mode_next  = run_mode;
        q_next         = q;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_shift(mode)) begin
                    // Burst request: latch only, no step on this edge.
                    if (count != '0) begin
                        run_mode_next  = mode;
                        remaining_next = count;
                        state_next     = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end else if (en) begin
                    q_next = step_fn(mode, q, msb_in, lsb_in, load_data);
                end
            end
            RUN: begin
                if (en) begin
                    // Serial inputs are sampled live, only the mode is latched.
                    q_next         = step_fn(run_mode, q, msb_in, lsb_in, load_data);
                    remaining_next = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            run_mode  <= M_HOLD;
            q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            run_mode  <= run_mode_next;
            q         <= q_next;
            // busy mirrors the RUN state and is the externally visible state flag.
            busy      <= (state_next == RUN);
            done      <= done_next;
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg_n.sv
module tb_univ_shift_reg_n;

  localparam int W  = 8;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic          msb_in;
  logic          lsb_in;
  logic [W-1:0]  load_data;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic          sout_r;
  logic          sout_l;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  univ_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .msb_in(msb_in),
    .lsb_in(lsb_in), .load_data(load_data), .start(start), .count(count),
    .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Integer arithmetic view of one step on a W-bit value.
  function automatic int m_step(input int md, input int v, input int mi, input int li, input int ld);
    int full;
    full = 1 << W;
    case (md)
      1: return (v / 2) + mi * (full / 2);
      2: return ((v * 2) % full) + li;
      3: return ld;
      4: return (v / 2) + (v % 2) * (full / 2);
      5: return ((v * 2) % full) + (v / (full / 2));
      6: return (v / 2) + ((v >= full / 2) ? full / 2 : 0);
      default: return v;
    endcase
  endfunction

  function automatic bit m_is_shift(input int md);
    return md == 1 || md == 2 || md == 4 || md == 5 || md == 6;
  endfunction

  int m_q = 0, m_rem = 0, m_mode = 0;
  bit m_done = 0;

  always begin
    @(posedge clk);
    if (rst === 1'b1) begin
      m_q = 0; m_rem = 0; m_done = 0;
    end else if (m_rem > 0) begin
      m_done = 0;
      if (en) begin
        m_q = m_step(m_mode, m_q, int'(msb_in), int'(lsb_in), int'(load_data));
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else begin
      m_done = 0;
      if (start && m_is_shift(int'(mode))) begin
        if (count != 0) begin
          m_mode = int'(mode);
          m_rem  = int'(count);
        end else begin
          m_done = 1;
        end
      end else if (en) begin
        m_q = m_step(int'(mode), m_q, int'(msb_in), int'(lsb_in), int'(load_data));
      end
    end
    #1;
    if (chk_en) begin
      check("model_q", 32'(q), 32'(m_q));
      check("model_busy", 32'(busy), 32'(m_rem > 0));
      check("model_done", 32'(done), 32'(m_done));
      check("model_sout_r", 32'(sout_r), 32'(m_q % 2));
      check("model_sout_l", 32'(sout_l), 32'(m_q / (1 << (W - 1))));
      check("busy_done_excl", 32'(busy && done), 32'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; en = 0; mode = 3'b000; msb_in = 0; lsb_in = 0;
    load_data = '0; start = 0; count = '0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    mode = 3'b011; load_data = v; en = 1; start = 0;
    tick();
    en = 0; mode = 3'b000;
  endtask

  task automatic single(input logic [2:0] m, input logic mi);
    mode = m; msb_in = mi; en = 1; start = 0;
    tick();
    en = 0; mode = 3'b000;
  endtask

  int busy_cycles;

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    chk_en = 1;
    check("reset_q", 32'(q), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // 1: reset mid-burst
    do_load(8'hA5);
    mode = 3'b010; start = 1; count = 4'd5; en = 0;
    tick();
    start = 0;
    tick();
    check("t1_pre_busy", 32'(busy), 32'h1);
    check("t1_pre_q", 32'(q), 32'hA5);
    rst = 1;
    tick();
    rst = 0;
    check("t1_rst_q", 32'(q), 32'h0);
    check("t1_rst_busy", 32'(busy), 32'h0);
    check("t1_rst_done", 32'(done), 32'h0);
    mode = 3'b010; lsb_in = 1; start = 1; count = 4'd2; en = 1;
    tick();
    start = 0; mode = 3'b000;
    check("t1_restart_busy", 32'(busy), 32'h1);
    tick();
    tick();
    check("t1_restart_q", 32'(q), 32'h03);
    check("t1_restart_done", 32'(done), 32'h1);
    idle_inputs();

    // 2: idle single steps
    do_load(8'h81); single(3'b100, 0); check("t2_rotr", 32'(q), 32'hC0);
    do_load(8'h81); single(3'b101, 0); check("t2_rotl", 32'(q), 32'h03);
    do_load(8'h80); single(3'b110, 0); check("t2_ashr", 32'(q), 32'hC0);
    do_load(8'h80); single(3'b001, 0); check("t2_shr", 32'(q), 32'h40);
    do_load(8'h3C);                    check("t2_load", 32'(q), 32'h3C);
    single(3'b111, 1);                 check("t2_rsvd", 32'(q), 32'h3C);

    // 3: SHL burst with expected queue
    do_load(8'h01);
    exp_q.push_back(8'h03); exp_q.push_back(8'h07); exp_q.push_back(8'h0F);
    mode = 3'b010; lsb_in = 1; start = 1; count = 4'd3; en = 1;
    tick();
    start = 0;
    check("t3_accept_q", 32'(q), 32'h01);
    busy_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) busy_cycles++;
      tick();
      check("t3_step_q", 32'(q), 32'(exp_q.pop_front()));
    end
    check("t3_busy_cycles", 32'(busy_cycles), 32'd3);
    check("t3_done", 32'(done), 32'h1);
    check("t3_busy_end", 32'(busy), 32'h0);
    tick();
    check("t3_done_once", 32'(done), 32'h0);
    idle_inputs();

    // 4: ROTL burst with stall
    do_load(8'h11);
    mode = 3'b101; start = 1; count = 4'd4; en = 1;
    tick();
    start = 0; mode = 3'b000;
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      en = !(i == 2 || i == 3);
      if (busy) busy_cycles++;
      tick();
      if (i == 2 || i == 3) check("t4_stall_q", 32'(q), 32'h44);
    end
    check("t4_busy_cycles", 32'(busy_cycles), 32'd6);
    check("t4_final_q", 32'(q), 32'h11);
    idle_inputs();

    // 5: count=0 burst and LOAD with start
    do_load(8'h5A);
    mode = 3'b001; start = 1; count = 4'd0; en = 1;
    tick();
    start = 0; en = 0;
    check("t5_zero_q", 32'(q), 32'h5A);
    check("t5_zero_busy", 32'(busy), 32'h0);
    check("t5_zero_done", 32'(done), 32'h1);
    tick();
    check("t5_zero_done_once", 32'(done), 32'h0);
    mode = 3'b011; load_data = 8'hE7; start = 1; count = 4'd3; en = 1;
    tick();
    start = 0; en = 0;
    check("t5_load_q", 32'(q), 32'hE7);
    check("t5_load_done", 32'(done), 32'h0);
    check("t5_load_busy", 32'(busy), 32'h0);
    idle_inputs();

    // 6: back-to-back bursts, mode changes ignored mid-burst
    do_load(8'h81);
    mode = 3'b100; start = 1; count = 4'd2; en = 1;
    tick();
    start = 0; mode = 3'b011; load_data = 8'hFF;
    tick();
    tick();
    check("t6_first_q", 32'(q), 32'h60);
    check("t6_first_done", 32'(done), 32'h1);
    mode = 3'b100; start = 1; count = 4'd2;
    tick();
    check("t6_second_busy", 32'(busy), 32'h1);
    start = 0; mode = 3'b010; lsb_in = 1;
    tick();
    tick();
    check("t6_second_q", 32'(q), 32'h18);
    idle_inputs();

    // random phase, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = 3'($urandom_range(0, 7));
      msb_in    = 1'($urandom_range(0, 1));
      lsb_in    = 1'($urandom_range(0, 1));
      load_data = W'($urandom_range(0, 255));
      start     = ($urandom_range(0, 5) == 0);
      count     = CW'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
